// File: rtl/lif_timestep_scheduler.sv
// Time-multiplexed LIF neuron update controller: walks every neuron once per tick,
// applies leak/integrate/fire/refractory, then publishes the spike vector in one cycle.
module lif_timestep_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 2,
    parameter int V_WIDTH   = 8,
    parameter int REFRAC    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 cfg_we,
    input  logic [V_WIDTH-1:0]   cfg_thresh,
    input  logic [2:0]           cfg_leak_shift,
    output logic                 cur_req,
    output logic [IDX_W-1:0]     cur_idx,
    input  logic                 cur_valid,
    input  logic [V_WIDTH-1:0]   cur_data,
    output logic [N_NEURONS-1:0] spikes,
    output logic                 spike_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                              state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [N_NEURONS-1:0][V_WIDTH-1:0]   v_q, v_d;
    logic [N_NEURONS-1:0][RW-1:0]        refrac_q, refrac_d;
    logic [V_WIDTH-1:0]                  thresh_q, thresh_d;
    logic [2:0]                          leak_q, leak_d;
    logic [V_WIDTH-1:0]                  thr_l_q, thr_l_d;
    logic [2:0]                          leak_l_q, leak_l_d;
    logic [N_NEURONS-1:0]                shadow_q, shadow_d;
    logic [N_NEURONS-1:0]                spikes_q, spikes_d;
    logic                                overrun_q, overrun_d;

    logic [V_WIDTH-1:0] v_cur;
    logic [V_WIDTH-1:0] leaked;
    logic [V_WIDTH:0]   sum;
    logic [V_WIDTH-1:0] sat;
    logic               fire;

    // Datapath for the neuron currently addressed; the carry bit drives saturation.
    assign v_cur  = v_q[idx_q];
    assign leaked = v_cur - (v_cur >> leak_l_q);
    assign sum    = {1'b0, leaked} + {1'b0, cur_data};
    assign sat    = sum[V_WIDTH] ? {V_WIDTH{1'b1}} : sum[V_WIDTH-1:0];
    assign fire   = (sat >= thr_l_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        v_d       = v_q;
        refrac_d  = refrac_q;
        thresh_d  = thresh_q;
        leak_d    = leak_q;
        thr_l_d   = thr_l_q;
        leak_l_d  = leak_l_q;
        shadow_d  = shadow_q;
        spikes_d  = spikes_q;
        overrun_d = overrun_q;

        if (cfg_we) begin
            thresh_d = cfg_thresh;
            leak_d   = cfg_leak_shift;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    thr_l_d  = thresh_q;
                    leak_l_d = leak_q;
                    idx_d    = '0;
                    shadow_d = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (tick) begin
                    overrun_d = 1'b1;
                end
                if (cur_valid) begin
                    if (refrac_q[idx_q] != '0) begin
                        refrac_d[idx_q] = refrac_q[idx_q] - RW'(1);
                        v_d[idx_q]      = '0;
                    end else if (fire) begin
                        shadow_d[idx_q] = 1'b1;
                        v_d[idx_q]      = '0;
                        refrac_d[idx_q] = RW'(REFRAC);
                    end else begin
                        v_d[idx_q] = sat;
                    end
                    // Spikes are loaded on the way into DONE so they are valid with the pulse.
                    if (idx_q == LAST_IDX) begin
                        spikes_d = shadow_d;
                        idx_d    = '0;
                        state_d  = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                if (tick) begin
                    overrun_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            v_q       <= '0;
            refrac_q  <= '0;
            thresh_q  <= V_WIDTH'(1) << (V_WIDTH - 1);
            leak_q    <= 3'd3;
            thr_l_q   <= V_WIDTH'(1) << (V_WIDTH - 1);
            leak_l_q  <= 3'd3;
            shadow_q  <= '0;
            spikes_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            v_q       <= v_d;
            refrac_q  <= refrac_d;
            thresh_q  <= thresh_d;
            leak_q    <= leak_d;
            thr_l_q   <= thr_l_d;
            leak_l_q  <= leak_l_d;
            shadow_q  <= shadow_d;
            spikes_q  <= spikes_d;
            overrun_q <= overrun_d;
        end
    end

    assign cur_req     = (state_q == REQ);
    assign cur_idx     = idx_q;
    assign busy        = (state_q != IDLE);
    assign spike_valid = (state_q == DONE);
    assign spikes      = spikes_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// Directed bench for lif_timestep_scheduler: integrate/fire, refractory, saturation,
// handshake stall, overrun/config timing, mid-timestep reset and zero threshold.
module tb_lif_timestep_scheduler;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       cfg_we;
    logic [7:0] cfg_thresh;
    logic [2:0] cfg_leak_shift;
    logic       cur_req;
    logic [1:0] cur_idx;
    logic       cur_valid;
    logic [7:0] cur_data;
    logic [3:0] spikes;
    logic       spike_valid;
    logic       busy;
    logic       overrun;

    logic [7:0] cur_tab [4];
    int         num_checks;
    int         num_passed;
    logic [3:0] spk;
    int         lat;

    lif_timestep_scheduler #(
        .N_NEURONS(4), .IDX_W(2), .V_WIDTH(8), .REFRAC(2)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .cfg_we(cfg_we), .cfg_thresh(cfg_thresh), .cfg_leak_shift(cfg_leak_shift),
        .cur_req(cur_req), .cur_idx(cur_idx), .cur_valid(cur_valid), .cur_data(cur_data),
        .spikes(spikes), .spike_valid(spike_valid), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The synapse side answers with the current for whichever neuron is addressed.
    assign cur_data = cur_tab[cur_idx];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs === exp) num_passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic setConfig(input logic [7:0] th, input logic [2:0] ls);
        @(negedge clk);
        cfg_we = 1'b1; cfg_thresh = th; cfg_leak_shift = ls;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic setCurrents(input logic [7:0] c0, c1, c2, c3);
        cur_tab[0] = c0; cur_tab[1] = c1; cur_tab[2] = c2; cur_tab[3] = c3;
    endtask

    // One timestep; k counts negedges after tick (k=1 shows idx0). Optional stall window
    // starting at stall_k, and optional overrun tick plus config write at ovr_k.
    task automatic applyStimulus(input int stall_k, input int stall_len, input int stall_idx,
                                 input int ovr_k, input logic [7:0] ovr_thresh,
                                 output logic [3:0] spk_o, output int lat_o);
        int k;
        int left;
        bit done;
        @(negedge clk);
        tick = 1'b1; cur_valid = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        k = 0; done = 0; left = stall_len; spk_o = 4'hx;
        while (!done && k < 64) begin
            k++;
            tick = 1'b0; cfg_we = 1'b0;
            if (spike_valid) begin
                done  = 1;
                spk_o = spikes;
            end else begin
                if (k >= stall_k && left > 0) begin
                    cur_valid = 1'b0;
                    left--;
                    checkOutput("stall_idx", 32'(cur_idx), 32'(stall_idx));
                    checkOutput("stall_busy", 32'(busy), 1);
                end else begin
                    cur_valid = 1'b1;
                end
                if (k == ovr_k + 1) begin
                    checkOutput("overrun_set", 32'(overrun), 1);
                    checkOutput("no_restart_idx", 32'(cur_idx), 32'(k - 1));
                end
                if (k == ovr_k) begin
                    tick = 1'b1; cfg_we = 1'b1; cfg_thresh = ovr_thresh;
                end
                @(negedge clk);
            end
        end
        tick = 1'b0; cfg_we = 1'b0; cur_valid = 1'b1;
        lat_o = k;
        if (!done) checkOutput("timeout", 0, 1);
    endtask

    initial begin
        num_checks = 0; num_passed = 0;
        rst = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_thresh = 8'd0;
        cfg_leak_shift = 3'd0; cur_valid = 1'b1;
        setCurrents(8'd0, 8'd0, 8'd0, 8'd0);
        doReset();

        @(negedge clk);
        checkOutput("rst_spikes", 32'(spikes), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_cur_req", 32'(cur_req), 0);
        checkOutput("rst_cur_idx", 32'(cur_idx), 0);
        checkOutput("rst_overrun", 32'(overrun), 0);
        checkOutput("rst_spike_valid", 32'(spike_valid), 0);

        // Integrate/fire then refractory on neuron 0.
        setConfig(8'd100, 3'd3);
        setCurrents(8'd60, 8'd0, 8'd0, 8'd0);
        applyStimulus(0, 0, 0, -1, 8'd0, spk, lat);
        checkOutput("t1_spikes", 32'(spk), 0);
        checkOutput("t1_latency", 32'(lat), 5);
        checkOutput("t1_v0", 32'(dut.v_q[0]), 60);
        @(negedge clk);
        checkOutput("t1_idle_busy", 32'(busy), 0);
        checkOutput("t1_pulse_end", 32'(spike_valid), 0);
        applyStimulus(0, 0, 0, -1, 8'd0, spk, lat);
        checkOutput("t2_fire", 32'(spk), 1);
        checkOutput("t2_v0", 32'(dut.v_q[0]), 0);
        @(negedge clk);
        checkOutput("spikes_hold", 32'(spikes), 1);
        applyStimulus(0, 0, 0, -1, 8'd0, spk, lat);
        checkOutput("t3_refrac", 32'(spk), 0);
        applyStimulus(0, 0, 0, -1, 8'd0, spk, lat);
        checkOutput("t4_refrac", 32'(spk), 0);
        checkOutput("t4_v0", 32'(dut.v_q[0]), 0);
        applyStimulus(0, 0, 0, -1, 8'd0, spk, lat);
        checkOutput("t5_spikes", 32'(spk), 0);
        checkOutput("t5_v0", 32'(dut.v_q[0]), 60);
        applyStimulus(0, 0, 0, -1, 8'd0, spk, lat);
        checkOutput("t6_refire", 32'(spk), 1);

        // Saturation: 200-25+200 clips to 255, which meets a 255 threshold.
        doReset();
        setConfig(8'd255, 3'd3);
        setCurrents(8'd0, 8'd0, 8'd200, 8'd0);
        applyStimulus(0, 0, 0, -1, 8'd0, spk, lat);
        checkOutput("sat_t1_spikes", 32'(spk), 0);
        checkOutput("sat_t1_v2", 32'(dut.v_q[2]), 200);
        applyStimulus(0, 0, 0, -1, 8'd0, spk, lat);
        checkOutput("sat_t2_fire", 32'(spk), 4);

        // Unstalled reference, then the same timestep stalled 5 cycles at idx 1.
        doReset();
        setConfig(8'd100, 3'd3);
        setCurrents(8'd60, 8'd120, 8'd30, 8'd100);
        applyStimulus(0, 0, 0, -1, 8'd0, spk, lat);
        checkOutput("ref_spikes", 32'(spk), 4'b1010);
        checkOutput("ref_latency", 32'(lat), 5);
        doReset();
        setConfig(8'd100, 3'd3);
        applyStimulus(2, 5, 1, -1, 8'd0, spk, lat);
        checkOutput("stall_spikes", 32'(spk), 4'b1010);
        checkOutput("stall_latency", 32'(lat), 10);

        // Overrun tick and config write mid-timestep; threshold 50 applies next tick only.
        doReset();
        setConfig(8'd100, 3'd3);
        setCurrents(8'd60, 8'd0, 8'd0, 8'd0);
        applyStimulus(0, 0, 0, 1, 8'd50, spk, lat);
        checkOutput("ovr_spikes", 32'(spk), 0);
        checkOutput("ovr_latency", 32'(lat), 5);
        applyStimulus(0, 0, 0, -1, 8'd0, spk, lat);
        checkOutput("newcfg_fire", 32'(spk), 1);
        checkOutput("ovr_sticky", 32'(overrun), 1);

        // Reset at idx 2 after a timestep that left spikes, potentials and refractory set.
        doReset();
        setConfig(8'd100, 3'd3);
        setCurrents(8'd60, 8'd120, 8'd30, 8'd100);
        applyStimulus(0, 0, 0, -1, 8'd0, spk, lat);
        checkOutput("pre_rst_spikes", 32'(spk), 4'b1010);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_idx", 32'(cur_idx), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_req", 32'(cur_req), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_spikes", 32'(spikes), 0);
        checkOutput("mid_rst_v", dut.v_q, 0);
        checkOutput("mid_rst_overrun", 32'(overrun), 0);
        applyStimulus(0, 0, 0, -1, 8'd0, spk, lat);
        checkOutput("post_rst_spikes", 32'(spk), 0);
        checkOutput("post_rst_v1", 32'(dut.v_q[1]), 120);
        checkOutput("post_rst_v3", 32'(dut.v_q[3]), 100);

        // Zero threshold: every non-refractory neuron fires, even with no current.
        setConfig(8'd0, 3'd3);
        setCurrents(8'd0, 8'd0, 8'd0, 8'd0);
        applyStimulus(0, 0, 0, -1, 8'd0, spk, lat);
        checkOutput("thresh0_all", 32'(spk), 4'b1111);

        $display("%0d/%0d checks passed", num_passed, num_checks);
        $finish;
    end

endmodule
